mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction cache and the data cache.
- Sits between the two caches' memory-side interfaces and the RAM model.
- Grants one requester at a time and holds the grant until RAM completes the word transfer.
- The data cache has priority, with a bounded-streak rule so instruction fetch cannot starve.

Parameters:
STARVE_LIMIT, 4, consecutive dcache grants allowed while iREN is pending before icache is forced in (range 1..15)
CNT_W, 4, width of the dcache streak counter; must hold STARVE_LIMIT

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  low for exactly the cycle iload is valid
iload  out  32  icache read data
dREN  in  1  dcache read request
dWEN  in  1  dcache write request; wins over dREN if both high
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  low for exactly the cycle the dcache access completes
dload  out  32  dcache read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- One clock CLK; reset nRST is asynchronous and active-low.
- Reset: state=IDLE, streak=0.
  - Outputs during reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iload and dload pass ramload through at all times.
- State IDLE:
  - RAM enables are 0; iwait=dwait=1.
  - Arbitration decides the next state:
    - dreq=dREN|dWEN.
    - If dreq and not (iREN and streak==STARVE_LIMIT), go to DGRANT.
    - Else if iREN, go to IGRANT.
    - Else stay in IDLE.
- State DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
  - iwait=1.
  - dwait=0 only when ramstate==ACCESS.
- State IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - dwait=1.
  - iwait=0 only when ramstate==ACCESS.
- Completion: when ramstate==ACCESS in a grant state, the next state is IDLE.
  - Every grant therefore costs one IDLE arbitration cycle.
  - A back-to-back requester is re-arbitrated in IDLE.
- BUSY, FREE and ERROR while granted: hold the grant and keep the owner's wait=1.
  - ERROR is never completed by this block; the RAM model must recover.
- Owner withdrawal: if the owner's request drops before ACCESS, go to IDLE next cycle.
  - RAM enables follow the request combinationally, so they drop in the same cycle.
  - The streak counter is unchanged.
- Streak counter, updated on completion only:
  - dcache completion with iREN high: streak+1, saturating at STARVE_LIMIT.
  - dcache completion with iREN low: streak=0.
  - icache completion: streak=0.
- Addresses and data are unmodified 32-bit pass-through. No buffering; the arbiter never stores data.
- Reset asserted mid-grant: immediate return to IDLE. RAM enables drop asynchronously with the state.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs igrants (32), dgrants (32), conflicts (32).
  - igrants and dgrants increment on each completed icache and dcache access.
  - conflicts increments on each IDLE cycle in which iREN and dreq are both high.
  - All three reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single icache read:
  - Stimulus: iREN=1, iaddr=0x40, RAM returns 0xDEADBEEF after ramstate BUSY,BUSY,ACCESS.
  - Required: IDLE 1 cycle, then ramREN=1, ramaddr=0x40; iwait=0 only in the ACCESS cycle with iload=0xDEADBEEF; dwait=1 throughout.
- Simultaneous request:
  - Stimulus: iREN=1 and dWEN=1 (daddr=0x80, dstore=0x1234) in the same IDLE cycle.
  - Required: DGRANT first with ramWEN=1, ramstore=0x1234; icache is granted on the next arbitration.
- Starvation bound:
  - Stimulus: dREN held high and iREN held high with STARVE_LIMIT=4.
  - Required: exactly 4 dcache completions, then an IGRANT; streak returns to 0.
- Withdrawal:
  - Stimulus: dREN drops while in DGRANT with ramstate=BUSY.
  - Required: ramREN=0 in that same cycle, IDLE next cycle, no dwait low pulse.
- Reset mid-grant:
  - Stimulus: nRST pulses low during IGRANT.
  - Required: ramREN=0 and iwait=1 immediately; the bench confirms state=IDLE.
- MEM_ARB_STATS_EN:
  - Stimulus: 3 icache reads, 2 dcache writes, 1 conflict.
  - Required: igrants=3, dgrants=2, conflicts=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: memory-side bus between the two caches, the shared RAM
// port and the arbiter. The arbiter connects through the master modport;
// the caches and the RAM model connect through the slave modport.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between icache and dcache.
// The dcache wins arbitration, except that after STARVE_LIMIT back-to-back
// dcache completions with iREN pending, the icache is forced in.
// Every grant returns to IDLE for one arbitration cycle after completion.
// Optional build macro MEM_ARB_STATS_EN adds igrants/dgrants/conflicts
// event counters as extra outputs.
//
//   state  | meaning
//   IDLE   | no owner; arbitrate between pending requests
//   DGRANT | dcache owns the RAM port until ACCESS or withdrawal
//   IGRANT | icache owns the RAM port until ACCESS or withdrawal
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   igrants,
    output logic [31:0]   dgrants,
    output logic [31:0]   conflicts
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] streak, streak_nxt;
    logic             dreq;
    logic             access;

    assign dreq      = bus.dREN | bus.dWEN;
    assign access    = (bus.ramstate == RAM_ACCESS);
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    // State register and dcache streak counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    // Arbitration, RAM port steering, wait handshakes and streak update.
    always_comb begin
        state_nxt    = state;
        streak_nxt   = streak;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        case (state)
            IDLE: begin
                if (dreq && !(bus.iREN && (streak == LIMIT))) begin
                    state_nxt = DGRANT;
                end else if (bus.iREN) begin
                    state_nxt = IGRANT;
                end
            end
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (!dreq) begin
                    // Withdrawal: release the port, streak untouched.
                    state_nxt = IDLE;
                end else if (access) begin
                    bus.dwait = 1'b0;
                    state_nxt = IDLE;
                    if (bus.iREN) begin
                        streak_nxt = (streak == LIMIT) ? streak : streak + 1'b1;
                    end else begin
                        streak_nxt = '0;
                    end
                end
            end
            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                // Follows iREN so a withdrawn fetch drops the enable at once.
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    bus.iwait  = 1'b0;
                    state_nxt  = IDLE;
                    streak_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    // Event counters: completed accesses per cache and contested IDLE cycles.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrants   <= '0;
            dgrants   <= '0;
            conflicts <= '0;
        end else begin
            if (state == IGRANT && bus.iREN && access) begin
                igrants <= igrants + 32'd1;
            end
            if (state == DGRANT && dreq && access) begin
                dgrants <= dgrants + 32'd1;
            end
            if (state == IDLE && bus.iREN && dreq) begin
                conflicts <= conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a latency-2 RAM model
// and a completion scoreboard. Build with MEM_ARB_STATS_EN to also check
// the event counters.
module tb_mem_arbiter;
    logic CLK;
    logic nRST;
    mem_arbiter_if bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] igrants, dgrants, conflicts;
`endif

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .igrants   (igrants),
        .dgrants   (dgrants),
        .conflicts (conflicts)
`endif
    );

    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2;

    typedef struct {
        bit          is_d;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM model: BUSY, BUSY, ACCESS for every enabled access.
    logic [31:0] mem [0:255];
    logic [1:0]  ram_cnt;
    assign bus.ramload  = mem[bus.ramaddr[9:2]];
    assign bus.ramstate = (bus.ramREN || bus.ramWEN) ? ((ram_cnt == 2'd2) ? R_ACCESS : R_BUSY) : R_FREE;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ram_cnt <= 2'd0;
            for (int k = 0; k < 256; k++) mem[k] <= pat(32'(k) << 2);
            mem[8'h10] <= 32'hDEAD_BEEF;
        end else if (bus.ramREN || bus.ramWEN) begin
            if (bus.ramstate == R_ACCESS) begin
                ram_cnt <= 2'd0;
                if (bus.ramWEN) mem[bus.ramaddr[9:2]] <= bus.ramstore;
            end else begin
                ram_cnt <= ram_cnt + 2'd1;
            end
        end else begin
            ram_cnt <= 2'd0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every wait-low cycle must match the oldest expected completion.
    always @(negedge CLK) begin
        if (nRST && (!bus.iwait || !bus.dwait)) begin
            if (q.size() == 0) begin
                chk("spurious_wait_low", {30'b0, bus.iwait, bus.dwait}, 32'h3);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("owner_is_d", 32'(!bus.dwait), 32'(e.is_d));
                chk("other_wait_high", 32'(e.is_d ? bus.iwait : bus.dwait), 32'h1);
                chk("done_addr", bus.ramaddr, e.addr);
                if (e.is_wr) begin
                    chk("done_ramWEN", 32'(bus.ramWEN), 32'h1);
                    chk("done_store", bus.ramstore, e.data);
                end else begin
                    chk("done_load", e.is_d ? bus.dload : bus.iload, e.data);
                end
            end
        end
    end

    task automatic push(input bit is_d, input bit is_wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_d = is_d; e.is_wr = is_wr; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic wait_size(input string tag, input int target);
        for (int i = 0; i < 100 && q.size() > target; i++) begin
            @(posedge CLK); #1;
        end
        chk(tag, 32'(q.size()), 32'(target));
    endtask

    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0;
        @(negedge CLK);
        chk("rst_iwait", 32'(bus.iwait), 32'h1);
        chk("rst_dwait", 32'(bus.dwait), 32'h1);
        chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_ramstore", bus.ramstore, 32'h0);
        next_cycle();
        nRST = 1'b1;
        next_cycle();

        // Single icache read.
        bus.iaddr = 32'h40; bus.iREN = 1;
        push(0, 0, 32'h40, 32'hDEAD_BEEF);
        #1 chk("t1_idle_ramREN", 32'(bus.ramREN), 32'h0);
        next_cycle();
        chk("t1_ramREN", 32'(bus.ramREN), 32'h1);
        chk("t1_ramaddr", bus.ramaddr, 32'h40);
        chk("t1_busy_iwait", 32'(bus.iwait), 32'h1);
        chk("t1_ramstore", bus.ramstore, 32'h0);
        wait_size("t1_done", 0);
        bus.iREN = 0;

        // Simultaneous request: dcache write first, then icache.
        bus.iaddr = 32'h44; bus.iREN = 1;
        bus.daddr = 32'h80; bus.dstore = 32'h1234; bus.dWEN = 1;
        push(1, 1, 32'h80, 32'h1234);
        push(0, 0, 32'h44, pat(32'h44));
        next_cycle();
        chk("t2_ramWEN", 32'(bus.ramWEN), 32'h1);
        chk("t2_ramREN", 32'(bus.ramREN), 32'h0);
        chk("t2_ramstore", bus.ramstore, 32'h1234);
        chk("t2_ramaddr", bus.ramaddr, 32'h80);
        wait_size("t2_d_done", 1);
        bus.dWEN = 0;
        wait_size("t2_i_done", 0);
        bus.iREN = 0;

        // Starvation bound: four dcache reads, forced icache, dcache again.
        bus.daddr = 32'h80; bus.dREN = 1;
        bus.iaddr = 32'h48; bus.iREN = 1;
        for (int k = 0; k < 4; k++) push(1, 0, 32'h80, 32'h1234);
        push(0, 0, 32'h48, pat(32'h48));
        push(1, 0, 32'h80, 32'h1234);
        wait_size("t3_done", 0);
        bus.dREN = 0; bus.iREN = 0;

        // Withdrawal during BUSY.
        bus.daddr = 32'h84; bus.dREN = 1;
        next_cycle();
        chk("t4_grant_ramREN", 32'(bus.ramREN), 32'h1);
        chk("t4_ramstate_busy", 32'(bus.ramstate), 32'(R_BUSY));
        bus.dREN = 0;
        #1 chk("t4_drop_ramREN", 32'(bus.ramREN), 32'h0);
        chk("t4_drop_dwait", 32'(bus.dwait), 32'h1);
        next_cycle();
        bus.dREN = 1;
        #1 chk("t4_idle_ramREN", 32'(bus.ramREN), 32'h0);
        push(1, 0, 32'h84, pat(32'h84));
        wait_size("t4_done", 0);
        bus.dREN = 0;

        // Reset asserted mid-grant.
        bus.iaddr = 32'h4C; bus.iREN = 1;
        next_cycle();
        chk("t5_grant_ramREN", 32'(bus.ramREN), 32'h1);
        chk("t5_grant_ramaddr", bus.ramaddr, 32'h4C);
        nRST = 1'b0;
        #1 chk("t5_rst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("t5_rst_iwait", 32'(bus.iwait), 32'h1);
        chk("t5_rst_ramaddr", bus.ramaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        #1 chk("t5_idle_ramREN", 32'(bus.ramREN), 32'h0);
        push(0, 0, 32'h4C, pat(32'h4C));
        wait_size("t5_done", 0);
        bus.iREN = 0;

        // Counter scenario: 3 icache reads, 2 dcache writes, 1 conflict.
        nRST = 1'b0;
        next_cycle();
        nRST = 1'b1;
        next_cycle();
        bus.iaddr = 32'h50; bus.iREN = 1;
        push(0, 0, 32'h50, pat(32'h50));
        wait_size("t6_i0", 0);
        bus.iaddr = 32'h54;
        push(0, 0, 32'h54, pat(32'h54));
        wait_size("t6_i1", 0);
        bus.iREN = 0;
        bus.daddr = 32'h90; bus.dstore = 32'hA5A5_0001; bus.dWEN = 1;
        push(1, 1, 32'h90, 32'hA5A5_0001);
        wait_size("t6_d0", 0);
        bus.daddr = 32'h94; bus.dstore = 32'hA5A5_0002;
        bus.iaddr = 32'h58; bus.iREN = 1;
        push(1, 1, 32'h94, 32'hA5A5_0002);
        push(0, 0, 32'h58, pat(32'h58));
        wait_size("t6_d1", 1);
        bus.dWEN = 0;
        wait_size("t6_i2", 0);
        bus.iREN = 0;
        next_cycle();
`ifdef MEM_ARB_STATS_EN
        chk("stats_igrants", igrants, 32'd3);
        chk("stats_dgrants", dgrants, 32'd2);
        chk("stats_conflicts", conflicts, 32'd1);
`endif
        chk("t6_idle_ramREN", 32'(bus.ramREN), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
